score_digit_renderer: RTL
=========================

Name: score_digit_renderer

Overview:
- Parametrised successor to the fixed score bitmap overlay.
- Holds the score as a BCD counter with increment, clear and saturation.
- Renders NUM_DIGITS glyphs from a 1-bit digit glyph ROM at integer SCALE, with optional leading-zero blanking.
- Sits in the pclk video domain beside the other sprite controllers; its rgb/on pair feeds the top-level priority mux.

Parameters:
- NUM_DIGITS, 4, number of BCD digits stored and drawn (1..8).
- SCALE_LOG2, 0, glyph magnification = 2**SCALE_LOG2 (0..2).
- LZ_BLANK, 1, 1 = leading zeros not drawn (on=0 in those cells); the least significant digit is always drawn.
- FG_COLOR, 3'b111, rgb for glyph pixels.
- BG_COLOR, 3'b000, rgb for non-glyph pixels inside a drawn cell.

Ports:
- pclk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- xcoord_ini  in  10  left edge of score area
- ycoord_ini  in  10  top edge of score area
- score_inc  in  1  one-cycle pulse, score += 1
- score_clr  in  1  one-cycle pulse, score := 0
- frame_start  in  1  one-cycle pulse at frame start; latches the display shadow
- rgb  out  3  pixel colour, valid when on=1
- on  out  1  overlay active for this pixel
- score_bcd  out  4*NUM_DIGITS  live BCD score, digit 0 in bits [3:0]
- overflow  out  1  sticky saturation flag

Behaviour:
Reset:
- Async assert: score, shadow, rgb, on and overflow all go to 0 immediately.
- Pipeline valid bits cleared.

Score counter:
- score_clr has priority over score_inc in the same cycle; clr also clears overflow.
- score_inc: BCD ripple add with per-digit 9->0 carry.
- At all-9s, inc leaves the score unchanged and sets overflow=1, which holds until clr or reset.
- score_bcd is the live register value, updated one edge after the pulse.

Display shadow:
- On frame_start the shadow loads the score value that is being updated on that same edge, i.e. the post-increment value when inc/clr coincide.
- Rendering uses only the shadow, so there is no mid-frame tearing.

Geometry:
- Cell width CW = 8<<SCALE_LOG2; height CH = 12<<SCALE_LOG2.
- Region: xcoord_ini <= pixel_x < xcoord_ini + NUM_DIGITS*CW, and ycoord_ini <= pixel_y < ycoord_ini + CH.
- Use 11-bit arithmetic so xcoord_ini + width cannot wrap.
- dx = pixel_x - xcoord_ini; cell = dx >> (3+SCALE_LOG2).
- Leftmost cell is the most significant digit: digit index = NUM_DIGITS-1-cell.
- Glyph column = (dx >> SCALE_LOG2) & 7.
- Glyph row = (pixel_y - ycoord_ini) >> SCALE_LOG2.

Blanking:
- With LZ_BLANK=1, a cell is blanked if it and every more significant digit of the shadow are 0, except digit 0.
- A blanked cell gives on=0.

Pipeline (latency exactly 2 pclk edges from pixel_x/pixel_y to rgb/on):
- Stage 0 (combinational): region test, blank test, ROM address = {digit value, row[3:0]}, column.
- Edge 1: ROM registers the row byte; stage-1 registers hold inside_and_drawn and column.
- Edge 2: on <= inside_and_drawn; rgb <= bit(7-column) of row byte ? FG_COLOR : BG_COLOR.
- When on=0, rgb=0.

Boundary and mid-operation rules:
- xcoord_ini/ycoord_ini are sampled in stage 0 and may change at any time; no state depends on them.
- Reset mid-line: outputs go to 0 immediately, and the first valid pixel appears 2 edges after rst deasserts.

Decomposition:
- Shared package: GLYPH_W=8, GLYPH_H=12, BCD digit typedef (4 bits), and the BLANK_CODE constant (4'hF).
- One sub-module: digit_glyph_rom.
  - Synchronous read, 8-bit address, 8-bit data, 1-cycle latency.
  - Holds digits 0-9; rows 12-15 and codes 10-15 read zero.
  - Bit 7 is the leftmost pixel.

Test Plan:
Defaults: NUM_DIGITS=4, SCALE_LOG2=0, xcoord_ini=100, ycoord_ini=40.
1. Assert rst mid-sweep -> on=0, rgb=0, score_bcd=16'h0000, overflow=0 in the same cycle; first on=1 pixel appears 2 edges after deassert.
2. 37 score_inc pulses -> score_bcd=16'h0037. Rendered value stays 0000 until frame_start; after frame_start, pixels x=116..131, y=40..51 produce "37" glyph bits matching the ROM.
3. Geometry probe, score 0037, LZ_BLANK=0 -> (100,40) on=1 and (131,51) on=1, each 2 edges later; (99,40), (132,40) and (100,52) on=0.
4. Load 9999 then one inc -> score_bcd stays 16'h9999, overflow=1. score_clr and score_inc in the same cycle -> 16'h0000, overflow=0.
5. LZ_BLANK=1 -> score 0037: x=100..115 on=0, x=116..131 on=1. Score 0000: only x=124..131 on=1.
6. SCALE_LOG2=1 -> region is 64x24. (101,41) uses glyph col 0, row 0; (102,40) uses col 1; (163,63) on=1; (164,63) on=0.

Source files
------------

// File: rtl/score_digit_renderer_pkg.sv
// Shared constants and types for the score digit renderer and its glyph ROM.
package score_digit_renderer_pkg;

   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 12;

   typedef logic [3:0] bcd_t;

   // Any code above 9 reads an all-zero glyph; used for blanked and out-of-region pixels.
   localparam bcd_t BLANK_CODE = 4'hF;

endpackage

// File: rtl/digit_glyph_rom.sv
// 8x12 1-bit glyph ROM for digits 0-9, synchronous read, bit 7 is the leftmost pixel.
module digit_glyph_rom
   import score_digit_renderer_pkg::*;
(
   input  logic       i_clk,
   input  logic [7:0] i_addr,
   output logic [7:0] o_data
);

   logic [95:0] w_glyph;
   logic [7:0]  w_row_byte;
   logic [7:0]  r_data;

   // NOTE: every combinational output gets a value on every path (default arm) so no latch is inferred.
   always_comb begin
      case (i_addr[7:4])
         4'd0:    w_glyph = 96'h7EC3C3C3C7CBD3E3C3C3C37E;
         4'd1:    w_glyph = 96'h1838781818181818181818_7E;
         4'd2:    w_glyph = 96'h7EC30303060C183060C0C0FF;
         4'd3:    w_glyph = 96'h7EC30303033E03030303C37E;
         4'd4:    w_glyph = 96'h060E1E3666C6FF0606060606;
         4'd5:    w_glyph = 96'hFFC0C0C0FE0303030303C37E;
         4'd6:    w_glyph = 96'h3E60C0C0FEC3C3C3C3C3C37E;
         4'd7:    w_glyph = 96'hFF0303060C18303030303030;
         4'd8:    w_glyph = 96'h7EC3C3C3C37EC3C3C3C3C37E;
         4'd9:    w_glyph = 96'h7EC3C3C3C3C37F030303067C;
         default: w_glyph = '0;
      endcase
      w_row_byte = 8'h00;
      if (i_addr[3:0] < 4'(GLYPH_H))
         w_row_byte = w_glyph[8*(GLYPH_H-1-int'(i_addr[3:0])) +: 8];
   end

   // NOTE: the read register is not reset; the contents are constant and the pipeline valid bit gates it.
   always_ff @(posedge i_clk) begin
      r_data <= w_row_byte;
   end

   assign o_data = r_data;

endmodule

// File: rtl/score_digit_renderer.sv
// BCD score counter with a frame-latched shadow, rendered as scaled glyph cells (2-edge pipeline).
module score_digit_renderer
   import score_digit_renderer_pkg::*;
#(
   parameter int         NUM_DIGITS = 4,
   parameter int         SCALE_LOG2 = 0,
   parameter bit         LZ_BLANK   = 1'b1,
   parameter logic [2:0] FG_COLOR   = 3'b111,
   parameter logic [2:0] BG_COLOR   = 3'b000
) (
   input  logic                    pclk,
   input  logic                    rst,
   input  logic [9:0]              pixel_x,
   input  logic [9:0]              pixel_y,
   input  logic [9:0]              xcoord_ini,
   input  logic [9:0]              ycoord_ini,
   input  logic                    score_inc,
   input  logic                    score_clr,
   input  logic                    frame_start,
   output logic [2:0]              rgb,
   output logic                    on,
   output logic [4*NUM_DIGITS-1:0] score_bcd,
   output logic                    overflow
);

   localparam logic [10:0] AREA_W = 11'(NUM_DIGITS * (GLYPH_W << SCALE_LOG2));
   localparam logic [10:0] AREA_H = 11'(GLYPH_H << SCALE_LOG2);

   logic [4*NUM_DIGITS-1:0] r_score, r_shadow, w_score_next;
   logic                    r_overflow, w_overflow_next, w_all_nines, w_carry;

   always_comb begin
      w_score_next    = r_score;
      w_overflow_next = r_overflow;
      w_all_nines     = 1'b1;
      w_carry         = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (r_score[4*i +: 4] != 4'd9) w_all_nines = 1'b0;
      if (score_clr) begin
         w_score_next    = '0;
         w_overflow_next = 1'b0;
      end else if (score_inc) begin
         if (w_all_nines) begin
            w_overflow_next = 1'b1;
         end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (w_carry) begin
                  if (r_score[4*i +: 4] == 4'd9) begin
                     w_score_next[4*i +: 4] = 4'd0;
                  end else begin
                     w_score_next[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                     w_carry = 1'b0;
                  end
               end
            end
         end
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_score    <= '0;
         r_overflow <= 1'b0;
         r_shadow   <= '0;
      end else begin
         r_score    <= w_score_next;
         r_overflow <= w_overflow_next;
         if (frame_start) r_shadow <= w_score_next;
      end
   end

   assign score_bcd = r_score;
   assign overflow  = r_overflow;

   logic [10:0]           w_dx, w_dy;
   logic                  w_inside, w_blank, w_draw, w_zero_run, w_unused;
   logic [2:0]            w_cell, w_dig_idx, w_col;
   logic [NUM_DIGITS-1:0] w_lz;
   bcd_t                  w_digit;
   logic [7:0]            w_rom_addr, w_rom_data;
   logic                  r_draw_s1;
   logic [2:0]            r_col_s1;

   // 11-bit arithmetic keeps xcoord_ini + width from wrapping near the screen edge.
   assign w_dx     = {1'b0, pixel_x} - {1'b0, xcoord_ini};
   assign w_dy     = {1'b0, pixel_y} - {1'b0, ycoord_ini};
   assign w_inside = (pixel_x >= xcoord_ini) && ({1'b0, pixel_x} < {1'b0, xcoord_ini} + AREA_W) &&
                     (pixel_y >= ycoord_ini) && ({1'b0, pixel_y} < {1'b0, ycoord_ini} + AREA_H);
   assign w_cell    = w_dx[3+SCALE_LOG2 +: 3];
   assign w_dig_idx = 3'(NUM_DIGITS - 1) - w_cell;
   assign w_col     = w_dx[SCALE_LOG2 +: 3];
   assign w_unused  = ^{w_dx, w_dy};

   always_comb begin
      w_zero_run = 1'b1;
      w_lz       = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_zero_run = w_zero_run && (r_shadow[4*i +: 4] == 4'd0);
         w_lz[i]    = w_zero_run;
      end
      w_digit = BLANK_CODE;
      w_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_dig_idx == 3'(i)) begin
            w_digit = r_shadow[4*i +: 4];
            w_blank = LZ_BLANK && (i != 0) && w_lz[i];
         end
      end
   end

   assign w_draw     = w_inside && !w_blank;
   assign w_rom_addr = {(w_draw ? w_digit : BLANK_CODE), w_dy[SCALE_LOG2 +: 4]};

   digit_glyph_rom u_rom (
      .i_clk  (pclk),
      .i_addr (w_rom_addr),
      .o_data (w_rom_data)
   );

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_draw_s1 <= 1'b0;
         r_col_s1  <= 3'd0;
         on        <= 1'b0;
         rgb       <= 3'b000;
      end else begin
         r_draw_s1 <= w_draw;
         r_col_s1  <= w_col;
         on        <= r_draw_s1;
         if (r_draw_s1) rgb <= w_rom_data[3'd7 - r_col_s1] ? FG_COLOR : BG_COLOR;
         else           rgb <= 3'b000;
      end
   end

endmodule
